// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph encodings, banner codes and converter state type
//               for the 4-digit scanned 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [7:0] GOOD_CODE = 8'd255;
    localparam logic [7:0] END_CODE  = 8'd253;

    // Active-low segment patterns, bit 0 = a .. bit 6 = g, bit 7 = dp (off)
    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_L     = 8'hC7;
    localparam logic [7:0] GLYPH_G     = 8'hC2;
    localparam logic [7:0] GLYPH_o     = 8'hA3;
    localparam logic [7:0] GLYPH_d     = 8'hA1;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_n     = 8'hAB;

    localparam logic [3:0][7:0] GLYPHS_RESET = {GLYPH_L, GLYPH_BLANK, GLYPH_BLANK, GLYPH_0};

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 8-bit binary to 3-digit BCD converter
//               (double-dabble, 8 shift/add-3 iterations, start/done handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);
    import seg7_pkg::*;

    conv_state_t r_state;
    conv_state_t w_state_next;
    logic [19:0] r_shift;
    logic [19:0] w_shift_next;
    logic [19:0] w_adj;
    logic [2:0]  r_iter;
    logic [2:0]  w_iter_next;

    // Add 3 to every BCD nibble that would overflow past 9 on the next shift
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[8 + 4*i +: 4] >= 4'd5) begin
                w_adj[8 + 4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_iter_next  = r_iter;
        case (r_state)
            CONV_IDLE: begin
                if (start) begin
                    w_shift_next = {12'd0, bin};
                    w_iter_next  = 3'd0;
                    w_state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                w_shift_next = {w_adj[18:0], 1'b0};
                w_iter_next  = r_iter + 3'd1;
                if (r_iter == 3'd7) begin
                    w_state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                w_state_next = CONV_IDLE;
            end
            default: begin
                w_state_next = CONV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CONV_IDLE;
            r_shift <= '0;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_iter  <= w_iter_next;
        end
    end

    assign busy = (r_state != CONV_IDLE);
    assign done = (r_state == CONV_DONE);
    assign bcd  = r_shift[19:8];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : 4-digit multiplexed 7-segment driver for the game score code,
//               with banner decoding, frame-synchronous commit and blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter logic [7:0]  GOOD_CODE    = seg7_pkg::GOOD_CODE,
    parameter logic [7:0]  END_CODE     = seg7_pkg::END_CODE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code,
    input  logic       end_flag,
    output logic [7:0] seg_n,
    output logic [3:0] dig_n
);
    import seg7_pkg::*;

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [DIV_W-1:0] c_div_last   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] c_blink_last = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_digit;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blank_phase;
    logic [7:0]       r_last_code;
    logic [3:0][7:0]  r_pending;
    logic [3:0][7:0]  r_glyphs;

    logic             w_digit_tick;
    logic             w_frame_tick;
    logic             w_conv_start;
    logic             w_conv_busy;
    logic             w_conv_done;
    logic [11:0]      w_bcd;
    logic [3:0][7:0]  w_mapped;
    logic             w_blank;
    logic [3:0]       w_digit_onehot;

    assign w_digit_tick   = (r_div == c_div_last);
    assign w_frame_tick   = w_digit_tick && (r_digit == 2'd0);
    assign w_conv_start   = !w_conv_busy && (code != r_last_code);
    assign w_blank        = r_blank_phase && end_flag;
    assign w_digit_onehot = 4'b0001 << r_digit;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_conv_start),
        .bin   (code),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    // Glyphs for the code held in r_last_code, valid while the converter reports done
    always_comb begin
        w_mapped = {GLYPH_L, digit_glyph(w_bcd[11:8]), digit_glyph(w_bcd[7:4]),
                    digit_glyph(w_bcd[3:0])};
        if (w_bcd[11:8] == 4'd0) begin
            w_mapped[2] = GLYPH_BLANK;
        end
        if (w_bcd[11:4] == 8'd0) begin
            w_mapped[1] = GLYPH_BLANK;
        end
        if (r_last_code == GOOD_CODE) begin
            w_mapped = {GLYPH_G, GLYPH_o, GLYPH_o, GLYPH_d};
        end else if (r_last_code == END_CODE) begin
            w_mapped = {GLYPH_E, GLYPH_n, GLYPH_d, GLYPH_BLANK};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_digit <= 2'd3;
        end else if (w_digit_tick) begin
            r_div   <= '0;
            r_digit <= r_digit - 2'd1;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blank_phase <= 1'b0;
        end else if (!end_flag) begin
            r_blink_cnt   <= '0;
            r_blank_phase <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt   <= '0;
                r_blank_phase <= ~r_blank_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Content only changes at frame boundaries; a same-cycle done bypasses r_pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_code <= 8'd0;
            r_pending   <= GLYPHS_RESET;
            r_glyphs    <= GLYPHS_RESET;
        end else begin
            if (w_conv_start) begin
                r_last_code <= code;
            end
            if (w_conv_done) begin
                r_pending <= w_mapped;
            end
            if (w_frame_tick) begin
                r_glyphs <= w_conv_done ? w_mapped : r_pending;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= GLYPH_BLANK;
            dig_n <= 4'hF;
        end else if (w_blank) begin
            seg_n <= GLYPH_BLANK;
            dig_n <= 4'hF;
        end else begin
            seg_n <= r_glyphs[r_digit];
            dig_n <= ~w_digit_onehot;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_display
// Description : Directed self-checking bench for seg7_scan_display
//               (SCAN_DIV=16, BLINK_FRAMES=2) with an expected-glyph queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

    typedef logic [3:0][7:0] glyphs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code;
    logic       end_flag;
    logic [7:0] seg_n;
    logic [3:0] dig_n;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] sb_q[$];
    glyphs_t    cur;

    seg7_scan_display #(
        .SCAN_DIV     (16),
        .BLINK_FRAMES (2),
        .GOOD_CODE    (8'd255),
        .END_CODE     (8'd253)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .code     (code),
        .end_flag (end_flag),
        .seg_n    (seg_n),
        .dig_n    (dig_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec_glyph(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic glyphs_t model(input int v);
        glyphs_t r;
        int h, t, o;
        if (v == 255) return {8'hC2, 8'hA3, 8'hA3, 8'hA1};
        if (v == 253) return {8'h86, 8'hAB, 8'hA1, 8'hFF};
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        r[3] = 8'hC7;
        r[2] = (h == 0) ? 8'hFF : dec_glyph(h);
        r[1] = (h == 0 && t == 0) ? 8'hFF : dec_glyph(t);
        r[0] = dec_glyph(o);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input glyphs_t g);
        for (int d = 3; d >= 0; d--) sb_q.push_back(g[d]);
    endtask

    // Called on the first sample of a frame; returns on the first sample of the next
    task automatic check_frame(input string tag);
        logic [7:0] exp_seg;
        logic [3:0] exp_dig;
        for (int d = 3; d >= 0; d--) begin
            exp_seg = 8'hxx;
            if (sb_q.size() != 0) exp_seg = sb_q.pop_front();
            exp_dig = ~(4'b0001 << d);
            for (int c = 0; c < 16; c++) begin
                if (c == 0 || c == 15) begin
                    check($sformatf("%s d%0d c%0d dig_n", tag, d, c), {4'h0, dig_n}, {4'h0, exp_dig});
                    check($sformatf("%s d%0d c%0d seg_n", tag, d, c), seg_n, exp_seg);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic check_blank(input string tag, input int frames);
        logic [7:0] exp_seg;
        for (int i = 0; i < frames * 4; i++) sb_q.push_back(8'hFF);
        for (int i = 0; i < frames * 4; i++) begin
            exp_seg = 8'hxx;
            if (sb_q.size() != 0) exp_seg = sb_q.pop_front();
            for (int c = 0; c < 16; c++) begin
                if (c == 0 || c == 15) begin
                    check($sformatf("%s slot%0d c%0d dig_n", tag, i, c), {4'h0, dig_n}, 8'h0F);
                    check($sformatf("%s slot%0d c%0d seg_n", tag, i, c), seg_n, exp_seg);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_frame_start(input string tag);
        logic [3:0] prev;
        bit found;
        prev  = dig_n;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dig_n == 4'b0111 && prev != 4'b0111) found = 1'b1;
            prev = dig_n;
        end
        if (!found) check({tag, " frame start timeout"}, 8'h00, 8'h01);
    endtask

    task automatic apply_code(input int v, input string tag);
        code = 8'(v);
        push_frame(cur);
        check_frame({tag, " hold"});
        cur = model(v);
        push_frame(cur);
        check_frame({tag, " new"});
    endtask

    initial begin
        rst_n    = 1'b0;
        code     = 8'd0;
        end_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("reset seg_n", seg_n, 8'hFF);
        check("reset dig_n", {4'h0, dig_n}, 8'h0F);

        rst_n = 1'b1;
        @(negedge clk);
        cur = {8'hC7, 8'hFF, 8'hFF, 8'hC0};
        push_frame(cur);
        check_frame("after reset");

        apply_code(7,   "code7");
        apply_code(123, "code123");
        apply_code(255, "good");
        apply_code(253, "end");
        apply_code(100, "code100");
        apply_code(40,  "code40");

        // Rapid 7 -> 9 -> 10: converter busy with 7, then picks up the latest value
        code = 8'd7;
        @(negedge clk);
        code = 8'd9;
        @(negedge clk);
        code = 8'd10;
        wait_frame_start("rapid");
        cur = {8'hC7, 8'hFF, 8'hF9, 8'hC0};
        push_frame(cur);
        check_frame("rapid L10");
        push_frame(cur);
        check_frame("rapid L10 stable");

        // Blink: two visible frames, two blank, two visible, then drop end_flag mid-blank
        end_flag = 1'b1;
        push_frame(cur);
        check_frame("blink vis0");
        push_frame(cur);
        check_frame("blink vis1");
        check_blank("blink blank", 2);
        push_frame(cur);
        check_frame("blink vis2");
        push_frame(cur);
        check_frame("blink vis3");
        repeat (36) @(negedge clk);
        check("midblank seg_n", seg_n, 8'hFF);
        check("midblank dig_n", {4'h0, dig_n}, 8'h0F);
        end_flag = 1'b0;
        @(negedge clk);
        check("unblank dig_n", {4'h0, dig_n}, 8'h0D);
        check("unblank seg_n", seg_n, cur[1]);

        // Reset mid-scan and mid-conversion
        code = 8'd200;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset seg_n", seg_n, 8'hFF);
        check("async reset dig_n", {4'h0, dig_n}, 8'h0F);
        @(negedge clk);
        check("held reset seg_n", seg_n, 8'hFF);
        check("held reset dig_n", {4'h0, dig_n}, 8'h0F);
        rst_n = 1'b1;
        @(negedge clk);
        cur = {8'hC7, 8'hFF, 8'hFF, 8'hC0};
        push_frame(cur);
        check_frame("rerelease L0");
        cur = model(200);
        push_frame(cur);
        check_frame("rerelease L200");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
